tmp_commit_unit: RTL
====================

Name: tmp_commit_unit

Overview:
- In-order retire and allocation controller for the 32-entry speculative temporary register file.
- Sits on the read side of that file. It hands out entry tags to dispatch as a circular tail pointer and reads the head entry through one read port.
- Once the head entry's result is valid, it retires the entry: writes the architectural register file or commits a store, then frees the entry.
- On a flush it discards all speculative state.

Parameters:
- DEPTH, 32, number of temp-file entries; must be a power of two.
- AW, 5, pointer width, log2(DEPTH).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- Alloc_req  in  1  dispatch requests a new entry.
- Alloc_grant  out  1  allocation accepted this cycle (combinational).
- Alloc_tag  out  AW  entry index granted; equals the tail pointer.
- Full  out  1  count == DEPTH.
- Empty  out  1  count == 0.
- Rd_Addr  out  AW  temp-file read address; always the head pointer.
- Rd_Data  in  73  temp-file entry. Fields: rd_reg[72:68], PC[67:36], Inst_type[35:34], spec_data[33:2], spec_valid[1], valid[0].
- Arf_we  out  1  architectural register write strobe.
- Arf_waddr  out  5  architectural destination register.
- Arf_wdata  out  32  committed data.
- Retire_pc  out  32  PC of the last retired entry.
- Clr_entry  out  1  clear the valid bit of entry Clr_addr.
- Clr_addr  out  AW  entry being freed.
- Clr_all  out  1  clear all temp-file entries.
- Store_req  out  1  store commit request to memory.
- Store_ack  in  1  memory accepted the store.
- Flush  in  1  mispredict flush, single-cycle pulse.

Behaviour:
- Reset values:
  - head = tail = 0, count = 0, state = RUN.
  - All registered outputs are 0: Arf_we, Arf_waddr, Arf_wdata, Retire_pc, Clr_entry, Clr_addr, Clr_all, Store_req.
  - Empty = 1, Full = 0.
- Allocation:
  - Alloc_grant = Alloc_req & ~Full & (state != FLUSH) & ~Flush.
  - On grant: tail <= tail+1, wrapping mod DEPTH.
  - A request while Full is ignored; tail is unchanged.
- Retire condition:
  - state == RUN, ~Empty, Rd_Data[0]==1 and Rd_Data[1]==1.
- Retire action by Inst_type; every retire registers its outputs and they are visible the cycle after the condition:
  - 00 ALU, 01 LOAD: Arf_we=1, Arf_waddr=rd_reg, Arf_wdata=spec_data. Also Clr_entry=1, Clr_addr=head, Retire_pc=PC. Then head+1, count-1.
  - 10 STORE: go to STORE_WAIT with Store_req=1. No Arf write. Head is not advanced yet.
  - 11 BRANCH: no Arf write. Clr_entry=1, Clr_addr=head, Retire_pc=PC. Then head+1, count-1.
- Pulsed outputs: Arf_we and Clr_entry are single-cycle pulses. At most one retire per cycle.
- STORE_WAIT:
  - Store_req is held high until the first cycle Store_ack==1.
  - On that cycle: Store_req<=0, Clr_entry=1, Clr_addr=head, Retire_pc=PC, head+1, count-1, state->RUN.
  - Store_ack in RUN is ignored.
- Simultaneous allocate and retire: count is unchanged and both pointers advance.
  - Allocation is permitted when count==DEPTH only if a retire frees an entry in the same cycle? No: Full blocks allocation regardless of a same-cycle retire.
- Head not ready (valid=0 or spec_valid=0): stall, nothing changes.
- Flush has the highest priority and is sampled in any state, including STORE_WAIT:
  - Next edge: head=tail=count=0, Store_req=0, no retire, state->FLUSH.
  - FLUSH lasts one cycle and asserts Clr_all=1; allocation is blocked. Then state->RUN.
  - A store already acked has committed. A pending, unacked store is dropped.
- Wrap-around: pointers are AW bits and wrap naturally. count is AW+1 bits, range 0..DEPTH.
- Reset mid-operation forces the reset values immediately (asynchronous).

Optional Feature:
- Macro: RETIRE_TRACE_EN.
- When defined:
  - A 32-bit internal retired-instruction counter is kept, reset to 0 and incremented on every retire, stores included at ack.
  - Each retire issues $display("INFO : TmpCommit : Retire pc=%h type=%d rd=%d data=%h count=%d").
  - Each flush issues $display of the number of discarded entries.
- When undefined: no counter and no displays.
- Ports and cycle behaviour are identical either way.

Test Plan:
- Reset, then 3 back-to-back Alloc_req -> tags 0,1,2 granted, count=3. Mark tag 0 as ALU, rd=5, data=0x1234, valid and spec_valid -> one cycle later Arf_we=1, Arf_waddr=5, Arf_wdata=0x1234, Clr_addr=0.
- Head entry valid but spec_valid=0 for 10 cycles -> no Arf_we, no Clr_entry. Set spec_valid -> retire the following cycle. Out-of-order-ready entry 1 is not retired before entry 0.
- STORE at head, Store_ack delayed 4 cycles -> Store_req high exactly until the ack cycle, Arf_we never asserted, head advances only after the ack.
- Allocate 32 entries -> Full=1 and the 33rd Alloc_req gets Alloc_grant=0. Retire one -> Full=0, and the next grant has tag 0 (wrap-around).
- Flush during STORE_WAIT with 6 entries live -> Store_req=0, Clr_all=1 for one cycle, Empty=1. The next allocation gets tag 0.
- Alloc_req and retire in the same cycle at count=4 -> count stays 4, head+1, tail+1.

Source files
------------

// File: rtl/tmp_commit_unit.sv
// tmp_commit_unit
//   In-order retire and allocation controller for the speculative temporary
//   register file. Hands out entry tags to dispatch from a circular tail
//   pointer, reads the head entry through a single read port and retires it
//   once its result is valid: ALU/LOAD entries write the architectural
//   register file, STOREs handshake with memory, BRANCHes simply retire.
//   A mispredict flush discards all speculative state.
//
// Optional build macro: RETIRE_TRACE_EN
//   Adds an internal retired-instruction counter and simulation trace
//   messages on every retire and flush. Ports and timing are unchanged.
//
// Ports:
//   clock, reset   system clock, asynchronous active-high reset
//   Alloc_req      dispatch requests a new entry
//   Alloc_grant    allocation accepted this cycle (combinational)
//   Alloc_tag      granted entry index (tail pointer)
//   Full, Empty    occupancy flags
//   Rd_Addr        temp-file read address (head pointer)
//   Rd_Data        temp-file entry {rd_reg, PC, Inst_type, spec_data,
//                  spec_valid, valid}
//   Arf_we/waddr/wdata  architectural register write (registered pulse)
//   Retire_pc      PC of the last retired entry
//   Clr_entry/Clr_addr  free one temp-file entry (registered pulse)
//   Clr_all        clear the whole temp file (asserted in the flush cycle)
//   Store_req      store commit request, held until Store_ack
//   Store_ack      memory accepted the store
//   Flush          mispredict flush, single-cycle pulse
module tmp_commit_unit #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          Alloc_req,
  output logic          Alloc_grant,
  output logic [AW-1:0] Alloc_tag,
  output logic          Full,
  output logic          Empty,
  output logic [AW-1:0] Rd_Addr,
  input  logic [72:0]   Rd_Data,
  output logic          Arf_we,
  output logic [4:0]    Arf_waddr,
  output logic [31:0]   Arf_wdata,
  output logic [31:0]   Retire_pc,
  output logic          Clr_entry,
  output logic [AW-1:0] Clr_addr,
  output logic          Clr_all,
  output logic          Store_req,
  input  logic          Store_ack,
  input  logic          Flush
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_STORE_WAIT = 2'd1,
    ST_FLUSH      = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    IT_ALU    = 2'b00,
    IT_LOAD   = 2'b01,
    IT_STORE  = 2'b10,
    IT_BRANCH = 2'b11
  } inst_type_t;

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  state_t      state;
  state_t      state_nxt;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   count;

  // Head entry fields
  logic [4:0]  ent_rd;
  logic [31:0] ent_pc;
  inst_type_t  ent_type;
  logic [31:0] ent_data;
  logic        ent_ready;

  assign ent_rd    = Rd_Data[72:68];
  assign ent_pc    = Rd_Data[67:36];
  assign ent_type  = inst_type_t'(Rd_Data[35:34]);
  assign ent_data  = Rd_Data[33:2];
  assign ent_ready = Rd_Data[1] & Rd_Data[0];

  // Retire decode
  logic retire_free;   // head entry leaves the window this cycle
  logic retire_arf;    // architectural register write this cycle
  logic store_start;   // store reaches head, begin memory handshake
  logic store_done;    // memory acknowledged the pending store

  assign Full        = (count == FULL_COUNT);
  assign Empty       = (count == '0);
  assign Alloc_tag   = tail;
  assign Rd_Addr     = head;
  assign Alloc_grant = Alloc_req & ~Full & (state != ST_FLUSH) & ~Flush;

  always_comb begin
    state_nxt   = state;
    retire_free = 1'b0;
    retire_arf  = 1'b0;
    store_start = 1'b0;
    store_done  = 1'b0;
    if (Flush) begin
      state_nxt = ST_FLUSH;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (!Empty && ent_ready) begin
            unique case (ent_type)
              IT_ALU, IT_LOAD: begin
                retire_arf  = 1'b1;
                retire_free = 1'b1;
              end
              IT_STORE: begin
                store_start = 1'b1;
                state_nxt   = ST_STORE_WAIT;
              end
              IT_BRANCH: begin
                retire_free = 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_STORE_WAIT: begin
          if (Store_ack) begin
            store_done  = 1'b1;
            retire_free = 1'b1;
            state_nxt   = ST_RUN;
          end
        end
        ST_FLUSH: begin
          state_nxt = ST_RUN;
        end
        default: begin
          state_nxt = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_RUN;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      Arf_we    <= 1'b0;
      Arf_waddr <= '0;
      Arf_wdata <= '0;
      Retire_pc <= '0;
      Clr_entry <= 1'b0;
      Clr_addr  <= '0;
      Clr_all   <= 1'b0;
      Store_req <= 1'b0;
    end else begin
      state     <= state_nxt;
      Arf_we    <= retire_arf;
      Clr_entry <= retire_free;
      Clr_all   <= Flush;

      if (retire_arf) begin
        Arf_waddr <= ent_rd;
        Arf_wdata <= ent_data;
      end
      if (retire_free) begin
        Clr_addr  <= head;
        Retire_pc <= ent_pc;
      end

      if (Flush) begin
        head      <= '0;
        tail      <= '0;
        count     <= '0;
        Store_req <= 1'b0;
      end else begin
        if (Alloc_grant) tail <= tail + 1'b1;
        if (retire_free) head <= head + 1'b1;
        // Allocate and free in the same cycle leave the occupancy unchanged.
        unique case ({Alloc_grant, retire_free})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
        if (store_start)     Store_req <= 1'b1;
        else if (store_done) Store_req <= 1'b0;
      end
    end
  end

`ifdef RETIRE_TRACE_EN
  logic [31:0] retire_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retire_count <= '0;
    end else if (retire_free) begin
      retire_count <= retire_count + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      if (retire_free) begin
        $display("INFO : TmpCommit : Retire pc=%h type=%d rd=%d data=%h count=%d",
                 ent_pc, ent_type, ent_rd, ent_data, retire_count + 32'd1);
      end
      if (Flush) begin
        $display("INFO : TmpCommit : Flush discarded %0d entries", count);
      end
    end
  end
`endif

endmodule
